// File: rtl/cla_pkg.sv
// +----------------------------------------------------------------------------+
// | cla_pkg: width constants and flag helper shared by the cla_16 adder        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cla_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct packed {
    logic sign;
    logic zero;
    logic parity;
    logic overflow;
  } flags_t;

  // Overflow compares operand signs against the result sign, so it needs the
  // operand MSBs alongside the sum.
  function automatic flags_t calc_flags(input logic [WIDTH-1:0] sum,
                                        input logic             a_msb,
                                        input logic             b_msb);
    flags_t f;
    f.sign     = sum[WIDTH-1];
    f.zero     = (sum == '0);
    f.parity   = ~^sum;
    f.overflow = (a_msb & b_msb & ~sum[WIDTH-1]) |
                 (~a_msb & ~b_msb & sum[WIDTH-1]);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla4.sv
// +----------------------------------------------------------------------------+
// | cla4: 4-bit carry-lookahead slice with group propagate/generate outputs    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla4
  import cla_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c0,
  output logic [SLICE-1:0] sum,
  output logic             grp_p,
  output logic             grp_g
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic             c1;
  logic             c2;
  logic             c3;

  assign p = a ^ b;
  assign g = a & b;

  // Each internal carry is a flat sum of products; nothing ripples.
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c0);

  assign sum   = p ^ {c3, c2, c1, c0};
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

`default_nettype wire

// File: rtl/cla_16.sv
// +----------------------------------------------------------------------------+
// | cla_16: 16-bit two-level carry-lookahead adder with registered sum/flags   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_16
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  logic             p0, p1, p2, p3;
  logic             g0, g1, g2, g3;
  logic             c4, c8, c12, c16;
  logic [SLICE-1:0] sum0, sum1, sum2, sum3;
  logic [WIDTH-1:0] sum_next;
  flags_t           flags_next;

  cla4 u_slice0 (.a(x[3:0]),   .b(y[3:0]),   .c0(cin), .sum(sum0), .grp_p(p0), .grp_g(g0));
  cla4 u_slice1 (.a(x[7:4]),   .b(y[7:4]),   .c0(c4),  .sum(sum1), .grp_p(p1), .grp_g(g1));
  cla4 u_slice2 (.a(x[11:8]),  .b(y[11:8]),  .c0(c8),  .sum(sum2), .grp_p(p2), .grp_g(g2));
  cla4 u_slice3 (.a(x[15:12]), .b(y[15:12]), .c0(c12), .sum(sum3), .grp_p(p3), .grp_g(g3));

  // Second lookahead level: slice carries straight from cin and group P/G.
  assign c4  = g0 | (p0 & cin);
  assign c8  = g1 | (p1 & g0) | (p1 & p0 & cin);
  assign c12 = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & cin);
  assign c16 = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
             | (p3 & p2 & p1 & p0 & cin);

  assign sum_next   = {sum3, sum2, sum1, sum0};
  assign flags_next = calc_flags(sum_next, x[WIDTH-1], y[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      cout     <= 1'b0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s        <= sum_next;
      cout     <= c16;
      sign     <= flags_next.sign;
      zero     <= flags_next.zero;
      parity   <= flags_next.parity;
      overflow <= flags_next.overflow;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_16.sv
// +----------------------------------------------------------------------------+
// | tb_cla_16: directed and random checks of cla_16 against an arithmetic model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cla_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic [15:0] s;
  logic        cout;
  logic        sign;
  logic        zero;
  logic        parity;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  // Packed result layout: {s, cout, sign, zero, parity, overflow}
  logic [20:0] exp_q;
  logic [20:0] got;

  cla_16 dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .cin(cin),
    .s(s), .cout(cout), .sign(sign), .zero(zero),
    .parity(parity), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {s, cout, sign, zero, parity, overflow};

  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [16:0] total;
    int          sres;
    logic [15:0] r;
    total = {1'b0, a} + {1'b0, b} + {16'd0, c};
    r     = total[15:0];
    sres  = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {r, total[16], r[15], (r == 16'd0), ($countones(r) % 2 == 0),
            (sres > 32767 || sres < -32768)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= model(x, y, cin);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (got !== exp_q) begin
        errors++;
        $display("FAIL stream: got %h expected %h (x=%h y=%h cin=%b)",
                 got, exp_q, x, y, cin);
      end
    end
  end

  task automatic check(input string name, input logic [20:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [20:0] want);
    @(negedge clk);
    x = a; y = b; cin = c;
    @(posedge clk);
    #1;
    check(name, want);
  endtask

  initial begin
    rst_n = 1'b0;
    x = 16'h1234; y = 16'h4321; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 21'h0);

    @(negedge clk);
    rst_n = 1'b1;
    x = 16'h0; y = 16'h0; cin = 1'b0;
    @(posedge clk);
    #1;
    check("zero_add", {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    cmp_en = 1'b1;

    apply("ten_plus_five", 16'd10,   16'd5,    1'b0, {16'h000F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    apply("pos_overflow",  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    apply("wrap_to_zero",  16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    apply("carry_in",      16'hFFFF, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    apply("neg_overflow",  16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    apply("cin_overflow",  16'h7FFF, 16'h0000, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    apply("mixed",         16'h1234, 16'h4321, 1'b1, {16'h5556, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 21'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
      x   = 16'($urandom);
      y   = 16'($urandom);
      cin = 1'($urandom);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_16.md
# cla_16

16-bit carry-lookahead adder with status flags, used as the add path of the datapath ALU. It adds two 16-bit operands and a carry-in, and produces a 16-bit sum, carry-out and four condition flags (Sign, Zero, Parity, Overflow). The carry network is a two-level lookahead: four 4-bit slices plus a group carry unit. All results are registered, giving one cycle of latency.

## Interface
Parameters:
- None. Width is fixed at 16 bits, from package constants.

Ports:
- clk  input  1  system clock; all outputs register on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- x  input  16  operand A, unsigned or two's complement.
- y  input  16  operand B.
- cin  input  1  carry-in.
- s  output  16  registered sum, x + y + cin mod 2^16.
- cout  output  1  registered carry out of bit 15.
- sign  output  1  registered copy of s[15].
- zero  output  1  registered; 1 when s == 0.
- parity  output  1  registered even-parity flag; 1 when s has an even number of ones (XNOR-reduce of s).
- overflow  output  1  registered two's-complement overflow.

## Operation
- Per bit: g_i = x_i & y_i and p_i = x_i ^ y_i.
- Each 4-bit slice produces its internal carries from c_in, p and g with lookahead equations, with no ripple inside the slice. It also produces group signals P = &p and G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- The group carry unit computes c4, c8, c12 and c16 from cin and the four (P, G) pairs using lookahead equations. There is no ripple between slices.
- Sum: s_i = p_i ^ c_i. The carry-out is cout = c16.
- Overflow: (x15 & y15 & ~s15) | (~x15 & ~y15 & s15), where s15 is the next sum value.
- Flags are computed from the combinational next sum and registered in the same cycle as s, so they always match the registered s.
- There is no handshake. A new operation is accepted every cycle.

## Timing
- Latency is 1 cycle: the inputs sampled at rising edge n appear on the outputs after edge n.
- Throughput is 1 operation per cycle. Inputs that change between edges have no effect until the next edge.
- Reset: while rst_n is low, all outputs are forced to 0 immediately and asynchronously. This includes zero and parity, which read 0 during reset even though s = 0.
- The first valid result appears after the first rising edge following reset release.
- If reset is asserted in the middle of a stream, the in-flight result is discarded and the outputs go to 0.
- The combinational path from x/y/cin to the register D inputs must pass through at most two lookahead levels, with no ripple chain.

## Structure
- Package cla_pkg contains:
  - WIDTH = 16 and SLICE = 4.
  - The slice count, WIDTH/SLICE = 4.
- Sub-module cla4: a 4-bit lookahead slice.
  - Inputs: a[3:0], b[3:0], c0.
  - Outputs: sum[3:0], group P, group G.
- cla_16 instantiates four cla4 slices, the group carry logic, the flag logic and the output registers.

## Test plan
For each case, apply the inputs and check the outputs after 1 cycle.
- Reset with rst_n = 0 and any inputs: s = 0, cout = 0, and all flags are 0. Release reset, then apply x = 0, y = 0, cin = 0: s = 0x0000, zero = 1, parity = 1, and all other outputs are 0.
- x = 10, y = 5, cin = 0: s = 0x000F, cout = 0, sign = 0, zero = 0, parity = 1, overflow = 0.
- x = 0x7FFF, y = 1, cin = 0: s = 0x8000, cout = 0, sign = 1, zero = 0, parity = 0, overflow = 1.
- x = 0xFFFF, y = 1, cin = 0: s = 0x0000, cout = 1, sign = 0, zero = 1, parity = 1, overflow = 0.
- Carry-in: x = 0xFFFF, y = 0, cin = 1 gives s = 0x0000 and cout = 1. Then x = 0x8000, y = 0x8000, cin = 0 gives s = 0x0000, cout = 1, overflow = 1, zero = 1.
- Random and back-to-back:
  - Apply 1000 random {x, y, cin} vectors, one per cycle.
  - Each result must match a reference model one cycle later.
  - Assert rst_n mid-stream: the outputs must go to 0 immediately.
